// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One shift-add or restoring shift-subtract step per clock.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] writeData,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               bzero_q, bzero_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               sa, sb;
  logic [WIDTH-1:0]   amag, bmag;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     drem;
  logic               dge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    sa   = ~op[0] & operandA[WIDTH-1];
    sb   = ~op[0] & operandB[WIDTH-1];
    amag = sa ? -operandA : operandA;
    bmag = sb ? -operandB : operandB;
  end

  // Datapath step terms, valid only while in RUN
  always_comb begin
    msum = {1'b0, work_q[2*WIDTH-1:WIDTH]}
         + (work_q[0] ? {1'b0, a_q} : '0);
    drem = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    dge  = drem >= {1'b0, b_q};
  end

  always_comb begin
    prod_fix = neg_q  ? -work_q : work_q;
    quo_fix  = neg_q  ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    rem_fix  = rneg_q ? -work_q[2*WIDTH-1:WIDTH]
                      : work_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    araw_d  = araw_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    work_d  = work_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          op_d    = op;
          a_d     = amag;
          b_d     = bmag;
          araw_d  = operandA;
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          bzero_d = (operandB == '0);
          work_d  = op[1] ? {{WIDTH{1'b0}}, amag}
                          : {{WIDTH{1'b0}}, bmag};
        end else begin
          if (hiWrite) hi_d = writeData;
          if (loWrite) lo_d = writeData;
        end
      end
      RUN: begin
        if (op_q[1]) begin
          work_d = {dge ? (drem[WIDTH-1:0] - b_q)
                        : drem[WIDTH-1:0],
                    work_q[WIDTH-2:0], dge};
        end else begin
          work_d = {msum, work_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        dbz_d   = op_q[1] & bzero_q;
        if (!op_q[1]) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (bzero_q) begin
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      araw_q  <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
      work_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      araw_q  <= araw_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
      work_q  <= work_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign divByZero = dbz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors,
// expected results queued at issue, checked on each done pulse.
module tb_mult_div_unit;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        hiWrite;
  logic        loWrite;
  logic [31:0] writeData;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .op        (op),
    .operandA  (operandA),
    .operandB  (operandB),
    .hiWrite   (hiWrite),
    .loWrite   (loWrite),
    .writeData (writeData),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .hi        (hi),
    .lo        (lo)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued result
  always @(negedge Clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_hi", 64'(hi), 64'(e.hi));
        chk("res_lo", 64'(lo), 64'(e.lo));
        chk("res_dbz", 64'(divByZero), 64'(e.dbz));
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen
  task automatic issue(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] eh,
                       input logic [31:0] el,
                       input logic ed,
                       input bit inject);
    int n;
    int cyc;
    exp_t e;
    e.hi = eh;
    e.lo = el;
    e.dbz = ed;
    start = 1'b1;
    op = o;
    operandA = a;
    operandB = b;
    sb.push_back(e);
    @(negedge Clk);
    start = 1'b0;
    operandA = ~a;
    operandB = ~b;
    n = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) n++;
      if (inject && cyc == 4) begin
        start = 1'b1;
        op = 2'b01;
        operandA = 32'd2;
        operandB = 32'd3;
        hiWrite = 1'b1;
        writeData = 32'h1234;
      end else begin
        start = 1'b0;
        hiWrite = 1'b0;
      end
      @(negedge Clk);
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_cycles", 64'(n), 64'd33);
    chk("busy_low_at_done", 64'(busy), 64'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Reset = 1'b1;
    start = 1'b0;
    op = 2'b00;
    operandA = '0;
    operandB = '0;
    hiWrite = 1'b0;
    loWrite = 1'b0;
    writeData = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(divByZero), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);

    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    issue(2'b00, 32'hFFFFFFFD, 32'd7,
          32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
    issue(2'b00, 32'h80000000, 32'h80000000,
          32'h40000000, 32'h00000000, 1'b0, 1'b0);
    issue(2'b11, 32'd100, 32'd7,
          32'd2, 32'd14, 1'b0, 1'b1);

    hiWrite = 1'b1;
    writeData = 32'h1234;
    @(negedge Clk);
    hiWrite = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_lo_kept", 64'(lo), 64'd14);

    loWrite = 1'b1;
    hiWrite = 1'b1;
    writeData = 32'hCAFE;
    @(negedge Clk);
    loWrite = 1'b0;
    hiWrite = 1'b0;
    chk("mtboth_hi", 64'(hi), 64'hCAFE);
    chk("mtboth_lo", 64'(lo), 64'hCAFE);

    issue(2'b10, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF,
          32'h00000000, 32'h80000000, 1'b0, 1'b0);
    issue(2'b11, 32'd5, 32'd0,
          32'd5, 32'hFFFFFFFF, 1'b1, 1'b0);
    issue(2'b10, 32'hFFFFFFFB, 32'd0,
          32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1'b0);

    start = 1'b1;
    op = 2'b01;
    operandA = 32'hFFFFFFFF;
    operandB = 32'hFFFFFFFF;
    @(negedge Clk);
    start = 1'b0;
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    repeat (40) @(negedge Clk);

    issue(2'b01, 32'd2, 32'd3,
          32'd0, 32'd6, 1'b0, 1'b0);

    for (int k = 0; k < 10 && sb.size() != 0; k++)
      @(negedge Clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
